// File: rtl/vec_result_serializer.sv
// Serializes one 16-lane FP16 vector result into BEATS sequential memory write beats, with back-to-back streaming.
// Optional build macro VSER_MASK_EN adds a per-lane mask; beats whose lanes are all masked off are skipped.
module vec_result_serializer #(
    parameter int LANES      = 16,
    parameter int LANE_W     = 16,
    parameter int BEAT_LANES = 4,
    parameter int ADDR_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*LANE_W-1:0]      in_data,
    input  logic [ADDR_W-1:0]            in_addr,
`ifdef VSER_MASK_EN
    input  logic [LANES-1:0]             in_mask,
    output logic [BEAT_LANES-1:0]        mem_lane_en,
`endif
    output logic                         mem_wr_en,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [BEAT_LANES*LANE_W-1:0] mem_wdata,
    input  logic                         mem_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int BEATS      = LANES / BEAT_LANES;
    localparam int BEAT_W     = BEAT_LANES * LANE_W;
    localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state, state_n;
    logic [BEAT_IDX_W-1:0]   beat, beat_n;
    logic [LANES*LANE_W-1:0] data_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    done_q, done_n, load;
    logic [BEATS-1:0]        nz_cur, nz_new;
    logic [BEAT_IDX_W:0]     nxt_cur, first_new;
    logic                    last_beat;

    // Lowest beat index >= start with a live lane group; MSB of the result is the found flag.
    function automatic logic [BEAT_IDX_W:0] find_from(input logic [BEATS-1:0] nz, input int start);
        logic                  found;
        logic [BEAT_IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int k = BEATS - 1; k >= 0; k--) begin
            if (nz[k] && (k >= start)) begin
                found = 1'b1;
                idx   = BEAT_IDX_W'(k);
            end
        end
        return {found, idx};
    endfunction

`ifdef VSER_MASK_EN
    logic [LANES-1:0] mask_q;

    always_comb begin
        for (int k = 0; k < BEATS; k++) begin
            nz_cur[k] = |mask_q[k*BEAT_LANES +: BEAT_LANES];
            nz_new[k] = |in_mask[k*BEAT_LANES +: BEAT_LANES];
        end
    end

    assign mem_lane_en = (state == SEND) ? mask_q[int'(beat)*BEAT_LANES +: BEAT_LANES] : '0;
`else
    assign nz_cur = '1;
    assign nz_new = '1;
`endif

    assign nxt_cur   = find_from(nz_cur, int'(beat) + 1);
    assign first_new = find_from(nz_new, 0);
    assign last_beat = ~nxt_cur[BEAT_IDX_W];

    // in_ready reopens combinationally while the final beat is being accepted, so vectors stream bubble-free.
    assign in_ready  = (state == IDLE) || ((state == SEND) && mem_ready && last_beat);
    assign mem_wr_en = (state == SEND);
    assign busy      = (state == SEND);
    assign done      = done_q;
    assign mem_addr  = (state == SEND) ? addr_q + ADDR_W'(beat) : '0;
    assign mem_wdata = (state == SEND) ? data_q[int'(beat)*BEAT_W +: BEAT_W] : '0;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_n = state;
        beat_n  = beat;
        done_n  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    if (first_new[BEAT_IDX_W]) begin
                        state_n = SEND;
                        beat_n  = first_new[BEAT_IDX_W-1:0];
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SEND: begin
                if (mem_ready) begin
                    if (!last_beat) begin
                        beat_n = nxt_cur[BEAT_IDX_W-1:0];
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                        if (in_valid) begin
                            load = 1'b1;
                            if (first_new[BEAT_IDX_W]) begin
                                state_n = SEND;
                                beat_n  = first_new[BEAT_IDX_W-1:0];
                            end
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // NOTE: the holding registers are explicitly cleared so nothing from an abandoned vector survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat   <= '0;
            done_q <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
`ifdef VSER_MASK_EN
            mask_q <= '0;
`endif
        end else begin
            beat   <= beat_n;
            done_q <= done_n;
            if (load) begin
                data_q <= in_data;
                addr_q <= in_addr;
`ifdef VSER_MASK_EN
                mask_q <= in_mask;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vec_result_serializer.sv
// Scoreboard bench for vec_result_serializer: the driver pushes expected beats at handshake,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_vec_result_serializer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [255:0]  in_data;
    logic [15:0]   in_addr;
    logic [15:0]   in_mask;
    logic [3:0]    mem_lane_en;
    logic          mem_wr_en;
    logic [15:0]   mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_ready;
    logic          busy;
    logic          done;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        logic [3:0]  lane_en;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   wr_cycles   = 0;
    int   done_cnt    = 0;
    int   run         = 0;
    int   max_run     = 0;
    logic pending_done = 1'b0;
    logic extra_done   = 1'b0;
    logic [255:0] v1, v2;

    always #5 clk = ~clk;

    vec_result_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_addr    (in_addr),
`ifdef VSER_MASK_EN
        .in_mask    (in_mask),
        .mem_lane_en(mem_lane_en),
`endif
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done)
    );

`ifndef VSER_MASK_EN
    assign mem_lane_en = 4'hF;
`endif

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks every presented beat against the queue head, pops on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending_done = 1'b0;
                run          = 0;
            end else begin
                if (pending_done || extra_done || done)
                    check("done_pulse", 64'(done), 64'(pending_done | extra_done));
                if (done) done_cnt++;
                pending_done = 1'b0;
                extra_done   = 1'b0;
                if (mem_wr_en) begin
                    wr_cycles++;
                    run++;
                    if (run > max_run) max_run = run;
                    if (sb.size() == 0) begin
                        check("unexpected_write", 64'(mem_wr_en), 64'd0);
                    end else begin
                        check("beat_addr", 64'(mem_addr), 64'(sb[0].addr));
                        check("beat_data", mem_wdata, sb[0].data);
`ifdef VSER_MASK_EN
                        check("beat_lane_en", 64'(mem_lane_en), 64'(sb[0].lane_en));
`endif
                        if (mem_ready) begin
                            pending_done = sb[0].last;
                            void'(sb.pop_front());
                        end
                    end
                end else begin
                    run = 0;
                end
            end
        end
    end

    // Drives one vector; on handshake pushes the expected beats. Leaves in_valid high for streaming.
    task automatic send_vec(input logic [255:0] d, input logic [15:0] a, input logic [15:0] m);
        logic rdy;
        logic ok;
        logic [3:0] lm;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        in_mask  = m;
        ok       = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
        end
        if (!ok) begin
            check("handshake_timeout", 64'd0, 64'd1);
        end else begin
            n = 0;
            for (int b = 0; b < 4; b++) begin
`ifdef VSER_MASK_EN
                lm = m[b*4 +: 4];
`else
                lm = 4'hF;
`endif
                if (lm != 4'h0) begin
                    sb.push_back('{addr: a + 16'(b), data: d[b*64 +: 64], lane_en: lm, last: 1'b0});
                    n++;
                end
            end
            if (n > 0) sb[sb.size()-1].last = 1'b1;
            else       extra_done = 1'b1;
        end
        #1;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 100 && !idle; c++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) idle = 1'b1;
        end
        if (!idle) check("idle_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic clear_stats();
        wr_cycles = 0;
        done_cnt  = 0;
        max_run   = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            v1[i*16 +: 16] = 16'h3C00 + 16'(i);
            v2[i*16 +: 16] = 16'h4000 + 16'(i * 17);
        end
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        in_mask   = 16'hFFFF;
        mem_ready = 1'b0;
        #12;
        check("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // 1: single vector, memory always ready
        clear_stats();
        mem_ready = 1'b1;
        send_vec(v1, 16'h0100, 16'hFFFF);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_first_addr", 64'(mem_addr), 64'h0100);
        check("t1_first_data", mem_wdata, 64'h3C03_3C02_3C01_3C00);
        wait_idle();
        check("t1_wr_cycles", 64'(wr_cycles), 64'd4);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);

        // 2: three-cycle stall on beat 1
        clear_stats();
        send_vec(v1, 16'h0100, 16'hFFFF);
        in_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("t2_stall_in_ready", 64'(in_ready), 64'd0);
            check("t2_stall_addr", 64'(mem_addr), 64'h0101);
            check("t2_stall_data", mem_wdata, 64'h3C07_3C06_3C05_3C04);
            tick();
        end
        mem_ready = 1'b1;
        wait_idle();
        check("t2_send_cycles", 64'(wr_cycles), 64'd7);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);

        // 3: two vectors back to back
        clear_stats();
        send_vec(v1, 16'h0100, 16'hFFFF);
        send_vec(v2, 16'h0200, 16'hFFFF);
        in_valid = 1'b0;
        wait_idle();
        check("t3_max_run", 64'(max_run), 64'd8);
        check("t3_wr_cycles", 64'(wr_cycles), 64'd8);
        check("t3_done_cnt", 64'(done_cnt), 64'd2);

        // 4: address wrap
        clear_stats();
        send_vec(v2, 16'hFFFE, 16'hFFFF);
        in_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t4_wrap_addr", 64'(mem_addr), 64'h0000);
        wait_idle();
        check("t4_wr_cycles", 64'(wr_cycles), 64'd4);

        // 5: reset while beat 2 is stalled
        send_vec(v1, 16'h0300, 16'hFFFF);
        in_valid = 1'b0;
        tick();
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        check("t5_beat2_addr", 64'(mem_addr), 64'h0302);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_wr_en", 64'(mem_wr_en), 64'd0);
        check("t5_rst_addr", 64'(mem_addr), 64'd0);
        check("t5_rst_wdata", mem_wdata, 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_done", 64'(done), 64'd0);
        sb.delete();
        tick();
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        clear_stats();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_post_in_ready", 64'(in_ready), 64'd1);
            check("t5_post_wr_en", 64'(mem_wr_en), 64'd0);
        end
        tick();

`ifdef VSER_MASK_EN
        // 6: masked beats are skipped; an all-zero mask writes nothing
        clear_stats();
        send_vec(v1, 16'h0400, 16'h0F0F);
        in_valid = 1'b0;
        wait_idle();
        check("t6_wr_cycles", 64'(wr_cycles), 64'd2);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);
        clear_stats();
        send_vec(v1, 16'h0500, 16'h0000);
        in_valid = 1'b0;
        wait_idle();
        check("t6_zero_wr_cycles", 64'(wr_cycles), 64'd0);
        check("t6_zero_done_cnt", 64'(done_cnt), 64'd1);
`endif

        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
